// File: rtl/piso_pkg.sv
// Shared types and limits for the serial transmitter.
// State encoding and legal parameter ranges.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

  localparam int WIDTH_MIN   = 2;
  localparam int WIDTH_MAX   = 32;
  localparam int CLK_DIV_MIN = 1;
  localparam int CLK_DIV_MAX = 255;
  localparam int GAP_MIN     = 0;
  localparam int GAP_MAX     = 15;

endpackage

// File: rtl/piso_tx_bit_tick.sv
// Bit-period divider for the serial transmitter.
// Ticks on the last clk of each serial bit.
module bit_tick #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick,
  output logic tick_nxt
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt_q;
  logic [DW-1:0] div_cnt_d;

  // Next divider count: clear wins, else wrap at the bit boundary.
  always_comb begin
    div_cnt_d = div_cnt_q;
    if (clr) begin
      div_cnt_d = '0;
    end else if (en) begin
      if (div_cnt_q == LAST) div_cnt_d = '0;
      else div_cnt_d = div_cnt_q + 1'b1;
    end
  end

  assign tick     = en && (div_cnt_q == LAST);
  assign tick_nxt = (div_cnt_d == LAST);

  // Divider count register.
  always_ff @(posedge clk) begin
    if (reset) div_cnt_q <= '0;
    else div_cnt_q <= div_cnt_d;
  end

endmodule

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter, MSB first.
// FSM, shift register and registered frame outputs.
module piso_tx
  import piso_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int CLK_DIV    = 1,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             dout,
  output logic             dout_valid,
  output logic             frame_start,
  output logic             done,
  output logic             busy
);

  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] BIT_TOP = BW'(WIDTH - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [3:0]       gap_cnt_q, gap_cnt_d;
  logic             hs;
  logic             tick;
  logic             tick_nxt;

  logic load_ready_q, load_ready_d;
  logic dout_q, dout_d;
  logic dout_valid_q, dout_valid_d;
  logic frame_start_q, frame_start_d;
  logic done_q, done_d;
  logic busy_q, busy_d;

  bit_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk      (clk),
    .reset    (reset),
    .en       (state_q == SHIFT),
    .clr      (hs),
    .tick     (tick),
    .tick_nxt (tick_nxt)
  );

  // Next-state, datapath and counter updates.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    hs        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load_valid) begin
          hs        = 1'b1;
          state_d   = SHIFT;
          shreg_d   = load_data;
          bit_cnt_d = BIT_TOP;
        end
      end
      SHIFT: begin
        if (tick) begin
          shreg_d = shreg_q << 1;
          if (bit_cnt_q == '0) begin
            state_d   = (GAP_CYCLES > 0) ? GAP : IDLE;
            gap_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q - 1'b1;
          end
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = IDLE;
        else gap_cnt_d = gap_cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output values for the cycle after this edge.
  always_comb begin
    load_ready_d  = (state_d == IDLE);
    busy_d        = (state_d != IDLE);
    dout_valid_d  = (state_d == SHIFT);
    dout_d        = (state_d == SHIFT) && shreg_d[WIDTH-1];
    frame_start_d = hs;
    done_d        = (state_d == SHIFT) && (bit_cnt_d == '0)
                    && tick_nxt;
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      shreg_q       <= '0;
      bit_cnt_q     <= '0;
      gap_cnt_q     <= '0;
      load_ready_q  <= 1'b1;
      dout_q        <= 1'b0;
      dout_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      bit_cnt_q     <= bit_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      load_ready_q  <= load_ready_d;
      dout_q        <= dout_d;
      dout_valid_q  <= dout_valid_d;
      frame_start_q <= frame_start_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
    end
  end

  assign load_ready  = load_ready_q;
  assign dout        = dout_q;
  assign dout_valid  = dout_valid_q;
  assign frame_start = frame_start_q;
  assign done        = done_q;
  assign busy        = busy_q;

endmodule
